fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the architectural fetch PC, runs the read/resp handshake with the instruction memory (I-cache), and holds each fetched word in a one-entry output buffer until IF/ID accepts it. It also absorbs control-flow redirects from branch resolution, including redirects that arrive while a memory read is still outstanding.

## Interface
- `RESET_PC`, default 32'h00000060: fetch address after reset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `imem_read`  out  1  read request to the I-cache; held high until `imem_resp`.
- `imem_address`  out  32  read address; stable while `imem_read`=1.
- `imem_rdata`  in  32  read data; valid only when `imem_resp`=1.
- `imem_resp`  in  1  one-cycle read-completion pulse.
- `redirect_valid`  in  1  taken branch/jump/mispredict: refetch from `redirect_pc`.
- `redirect_pc`  in  32  redirect target.
- `ready_in`  in  1  IF/ID load enable; pipeline not stalled.
- `valid_out`  out  1  output buffer holds a fetched instruction.
- `instr_out`  out  32  buffered instruction; 32'h00000013 (NOP) when `valid_out`=0.
- `pc_out`  out  32  PC of the buffered instruction.
- `pc_4_out`  out  32  `pc_out` + 4, modulo 2^32.
- `misalign_err`  out  1  sticky misaligned-redirect flag (see Configuration).

## Operation
- Registers: `state` ∈ {IDLE, REQ, DROP}, `fetch_pc`, `pend_pc`, `buf_valid`, `buf_instr`, `buf_pc`.
- `imem_read` = (state==REQ || state==DROP); `imem_address` = `fetch_pc`.
- `consume` = `buf_valid` && `ready_in` && !`redirect_valid`.
- Reset: state=IDLE, `fetch_pc`=RESET_PC, `pend_pc`=0, `buf_valid`=0, `buf_instr`=0, `buf_pc`=0, `misalign_err`=0. Outputs under reset: `imem_read`=0, `valid_out`=0, `instr_out`=NOP, `pc_out`=0, `pc_4_out`=4.
- IDLE:
  - on redirect: `buf_valid`<=0, `fetch_pc`<=`redirect_pc`, go to REQ.
  - else if !`buf_valid` or `consume`: `buf_valid`<=0, go to REQ.
  - else stay in IDLE.
- REQ:
  - on `imem_resp` && !redirect: `buf_instr`<=`imem_rdata`, `buf_pc`<=`fetch_pc`, `buf_valid`<=1, `fetch_pc`<=`fetch_pc`+4, go to IDLE.
  - on `imem_resp` && redirect: drop the data, `fetch_pc`<=`redirect_pc`, stay in REQ (new read starts next cycle).
  - on redirect without `imem_resp`: `pend_pc`<=`redirect_pc`, go to DROP; `fetch_pc` is held so the outstanding address stays stable.
- DROP: keep the read asserted at the old address.
  - a further redirect overwrites `pend_pc`.
  - on `imem_resp`: discard the data, `fetch_pc`<=(redirect this cycle ? `redirect_pc` : `pend_pc`), go to REQ.
- Any redirect clears `buf_valid` in the same edge, in every state. Redirect wins over `consume`.
- REQ is only entered with the buffer empty, so a response never overwrites an unconsumed instruction.
- PC arithmetic is 32-bit and wraps: 32'hFFFFFFFC + 4 = 0.

## Timing
- First `imem_read` is asserted on the cycle after `rst` deasserts.
- Response to `valid_out`: 1 cycle (`imem_resp` at edge t, `valid_out`=1 from t+1).
- Back-to-back fetch: one-cycle IDLE bubble between the consume edge and the next read. Minimum of 2 cycles per instruction plus cache latency.
- Redirect to first request at the new target:
  - from IDLE or REQ with `imem_resp`: next cycle.
  - from REQ without `imem_resp`: the cycle after the stale response.
- `rst` mid-request abandons the read; the I-cache shares `rst`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - `redirect_pc[1:0]` is forced to 2'b00 before use.
  - `misalign_err` is set (sticky until `rst`) on any accepted redirect with nonzero `redirect_pc[1:0]`.
- Not defined:
  - `redirect_pc` is used unmodified.
  - `misalign_err` is tied to 0.

## Test plan
- Reset with RESET_PC=0x60, cache answers 3 cycles after each read, `ready_in`=1 -> addresses 0x60, 0x64, 0x68 in order; `pc_out`/`pc_4_out` = 0x60/0x64, then 0x64/0x68; `valid_out` pulses once per word.
- Hold `ready_in`=0 for 10 cycles with the buffer full -> `imem_read` stays 0; `instr_out`/`pc_out` stay stable. Release -> next read at `pc_out`+4.
- Redirect to 0x200 two cycles into an outstanding read at 0x64 -> address stays 0x64 until `imem_resp`; that word never reaches `valid_out`; next read at 0x200.
- Redirect to 0x300 on the same cycle as `imem_resp` for 0x64 -> no `valid_out`; read at 0x300 the next cycle.
- Redirect to 0x400 then 0x500 while in DROP -> only 0x500 is fetched.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 0x102 -> read at 0x100; `misalign_err`=1 until `rst`.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ============================================================================
// Module  : fetch_unit_if
// Brief   : Fetch-stage bundle: I-cache read/resp, redirect input, IF/ID output.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface fetch_unit_if;
    logic        imem_read;
    logic [31:0] imem_address;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_4_out;
    logic        misalign_err;

    // master: the fetch unit itself; slave: cache + pipeline side
    modport master (
        output imem_read, imem_address, valid_out, instr_out, pc_out, pc_4_out, misalign_err,
        input  imem_rdata, imem_resp, redirect_valid, redirect_pc, ready_in
    );

    modport slave (
        input  imem_read, imem_address, valid_out, instr_out, pc_out, pc_4_out, misalign_err,
        output imem_rdata, imem_resp, redirect_valid, redirect_pc, ready_in
    );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : Instruction fetch stage with one-entry output buffer and redirect
//           handling across an outstanding I-cache read.
//           Optional: FETCH_ALIGN_CHECK_EN (force-align redirects, sticky flag).
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
    input  wire logic    clk,
    input  wire logic    rst,
    fetch_unit_if.master bus
);

    localparam logic [31:0] C_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_pend_pc;
    logic        r_buf_valid;
    logic [31:0] r_buf_instr;
    logic [31:0] r_buf_pc;

    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_consume;

    assign w_redir   = bus.redirect_valid;
    assign w_consume = r_buf_valid && bus.ready_in && !w_redir;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    assign w_redir_pc = {bus.redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_redir && (bus.redirect_pc[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign bus.misalign_err = r_misalign;
`else
    assign w_redir_pc       = bus.redirect_pc;
    assign bus.misalign_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_fetch_pc  <= RESET_PC;
            r_pend_pc   <= 32'd0;
            r_buf_valid <= 1'b0;
            r_buf_instr <= 32'd0;
            r_buf_pc    <= 32'd0;
        end else begin
            // A redirect kills the buffered word regardless of state
            if (w_redir) begin
                r_buf_valid <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_redir) begin
                        r_fetch_pc <= w_redir_pc;
                        r_state    <= REQ;
                    end else if (!r_buf_valid || w_consume) begin
                        r_buf_valid <= 1'b0;
                        r_state     <= REQ;
                    end
                end

                REQ: begin
                    if (bus.imem_resp) begin
                        if (w_redir) begin
                            r_fetch_pc <= w_redir_pc;
                        end else begin
                            r_buf_instr <= bus.imem_rdata;
                            r_buf_pc    <= r_fetch_pc;
                            r_buf_valid <= 1'b1;
                            r_fetch_pc  <= r_fetch_pc + 32'd4;
                            r_state     <= IDLE;
                        end
                    end else if (w_redir) begin
                        // Address must stay stable until the stale read completes
                        r_pend_pc <= w_redir_pc;
                        r_state   <= DROP;
                    end
                end

                DROP: begin
                    if (w_redir) begin
                        r_pend_pc <= w_redir_pc;
                    end
                    if (bus.imem_resp) begin
                        r_fetch_pc <= w_redir ? w_redir_pc : r_pend_pc;
                        r_state    <= REQ;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_read    = (r_state == REQ) || (r_state == DROP);
    assign bus.imem_address = r_fetch_pc;
    assign bus.valid_out    = r_buf_valid;
    assign bus.instr_out    = r_buf_valid ? r_buf_instr : C_NOP;
    assign bus.pc_out       = r_buf_pc;
    assign bus.pc_4_out     = r_buf_pc + 32'd4;

endmodule

`default_nettype wire
